// File: rtl/mips_ctrl_fsm.sv
// mips_ctrl_fsm -- multi-cycle control sequencer for the 8-bit MIPS-style core.
//
// Fetches 16-bit instructions over a req/ack handshake, latches the register
// fields, owns the PC, resolves BRZ branches and implements HALT. The 3-bit
// current_state is broadcast to the register file and ALU, which decode EX
// and RWB directly, so the state encodings are fixed.
//
// Parameters:
//   PC_W    program counter / instruction address width (4..16)
//   RST_PC  PC value loaded on reset
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-low reset (0 = reset)
//   run            start/continue enable, sampled in IDLE and HALT
//   imem_req       instruction fetch request (registered)
//   imem_addr      fetch address, combinationally equal to pc
//   imem_ack       fetch complete, imem_data valid this cycle
//   imem_data      instruction {OPCODE, RD, RA, RB}
//   current_state  sequencer state broadcast to the datapath
//   OPCODE/RA/RB/RD latched instruction fields
//   rf_we          register write strobe, high only in RWB
//   rs_data        register-file read port 0
//   pc             current program counter
//   halted         high while in HALT
//
// Optional build macro MIPS_CTRL_PERF_EN adds saturating 16-bit counters:
//   retired_cnt    instructions retired (EX->IF, RWB->IF, EX->HALT)
//   stall_cnt      IF cycles spent waiting for imem_ack

module mips_ctrl_fsm #(
    parameter int unsigned     PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic [2:0]      current_state,
    output logic [3:0]      OPCODE,
    output logic [3:0]      RA,
    output logic [3:0]      RB,
    output logic [3:0]      RD,
    output logic            rf_we,
    input  logic [7:0]      rs_data,
    output logic [PC_W-1:0] pc,
`ifdef MIPS_CTRL_PERF_EN
    output logic [15:0]     retired_cnt,
    output logic [15:0]     stall_cnt,
`endif
    output logic            halted
);

    localparam logic [2:0] S_IDLE = 3'b111;
    localparam logic [2:0] S_IF   = 3'b000;
    localparam logic [2:0] S_ID   = 3'b001;
    localparam logic [2:0] S_RR   = 3'b010;
    localparam logic [2:0] S_EX   = 3'b011;
    localparam logic [2:0] S_RWB  = 3'b100;
    localparam logic [2:0] S_HALT = 3'b101;

    localparam logic [3:0] OP_STORE = 4'd11;
    localparam logic [3:0] OP_BRZ   = 4'd12;
    localparam logic [3:0] OP_HALT  = 4'd15;

    logic [2:0] next_state;
    logic       run_q;
    logic [7:0] br_target;

    assign imem_addr = pc;
    assign br_target = {RD, RB};

    always_comb begin
        next_state = current_state;
        case (current_state)
            S_IDLE:  if (run) next_state = S_IF;
            S_IF:    if (imem_ack) next_state = S_ID;
            S_ID:    next_state = S_RR;
            S_RR:    next_state = S_EX;
            S_EX: begin
                case (OPCODE)
                    OP_HALT:          next_state = S_HALT;
                    OP_BRZ, OP_STORE: next_state = S_IF;
                    default:          next_state = S_RWB;
                endcase
            end
            S_RWB:   next_state = S_IF;
            // Restart only on a run edge observed while halted; a held level
            // carried into HALT has run_q already high.
            S_HALT:  if (run && !run_q) next_state = S_IF;
            default: next_state = S_IDLE;
        endcase
    end

    // imem_req/rf_we/halted are registered copies of the decoded next state,
    // so they line up exactly with current_state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            current_state <= S_IDLE;
            pc            <= RST_PC;
            OPCODE        <= '0;
            RA            <= '0;
            RB            <= '0;
            RD            <= '0;
            imem_req      <= 1'b0;
            rf_we         <= 1'b0;
            halted        <= 1'b0;
            run_q         <= 1'b0;
        end else begin
            current_state <= next_state;
            imem_req      <= (next_state == S_IF);
            rf_we         <= (next_state == S_RWB);
            halted        <= (next_state == S_HALT);
            run_q         <= run;
            if (current_state == S_IF && imem_ack) begin
                OPCODE <= imem_data[15:12];
                RD     <= imem_data[11:8];
                RA     <= imem_data[7:4];
                RB     <= imem_data[3:0];
                pc     <= pc + PC_W'(1);
            end
            if (current_state == S_EX && OPCODE == OP_BRZ && rs_data == 8'd0)
                pc <= PC_W'(br_target);
        end
    end

`ifdef MIPS_CTRL_PERF_EN
    logic retire;
    logic stall;

    assign retire = (current_state == S_RWB) ||
                    (current_state == S_EX && next_state != S_RWB);
    assign stall  = (current_state == S_IF) && !imem_ack;

    always_ff @(posedge clk) begin
        if (!reset) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (retire && retired_cnt != '1) retired_cnt <= retired_cnt + 16'd1;
            if (stall && stall_cnt != '1)    stall_cnt   <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// tb_mips_ctrl_fsm -- directed self-checking bench for mips_ctrl_fsm.
// u_dut uses PC_W=8 for the main sequence; u_w4 uses PC_W=4 for PC wrap and
// branch-target truncation.

module tb_mips_ctrl_fsm;

    localparam logic [2:0] S_IDLE = 3'b111;
    localparam logic [2:0] S_IF   = 3'b000;
    localparam logic [2:0] S_ID   = 3'b001;
    localparam logic [2:0] S_RR   = 3'b010;
    localparam logic [2:0] S_EX   = 3'b011;
    localparam logic [2:0] S_RWB  = 3'b100;
    localparam logic [2:0] S_HALT = 3'b101;

    logic        clk = 1'b0;
    logic        reset, run, imem_ack;
    logic [15:0] imem_data;
    logic [7:0]  rs_data;
    logic        imem_req, rf_we, halted;
    logic [7:0]  imem_addr, pc;
    logic [2:0]  current_state;
    logic [3:0]  OPCODE, RA, RB, RD;

    logic        reset2, run2, ack2;
    logic [15:0] data2;
    logic [7:0]  rs2;
    logic        req2, we2, halted2;
    logic [3:0]  addr2, pc2;
    logic [2:0]  state2;
    logic [3:0]  op2, ra2, rb2, rd2;

`ifdef MIPS_CTRL_PERF_EN
    logic [15:0] retired_cnt, stall_cnt, retired2, stall2;
`endif

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    mips_ctrl_fsm #(.PC_W(8), .RST_PC(8'h00)) u_dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .current_state(current_state),
        .OPCODE(OPCODE), .RA(RA), .RB(RB), .RD(RD),
        .rf_we(rf_we), .rs_data(rs_data), .pc(pc),
`ifdef MIPS_CTRL_PERF_EN
        .retired_cnt(retired_cnt), .stall_cnt(stall_cnt),
`endif
        .halted(halted)
    );

    mips_ctrl_fsm #(.PC_W(4), .RST_PC(4'h0)) u_w4 (
        .clk(clk), .reset(reset2), .run(run2),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_data(data2),
        .current_state(state2),
        .OPCODE(op2), .RA(ra2), .RB(rb2), .RD(rd2),
        .rf_we(we2), .rs_data(rs2), .pc(pc2),
`ifdef MIPS_CTRL_PERF_EN
        .retired_cnt(retired2), .stall_cnt(stall2),
`endif
        .halted(halted2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One step, then check state, request, write strobe and fetch address.
    task automatic stp(input string tag, input logic [2:0] st, input logic req,
                       input logic we, input logic [7:0] addr);
        step();
        chk({tag, ".state"}, 32'(current_state), 32'(st));
        chk({tag, ".req"},   32'(imem_req),      32'(req));
        chk({tag, ".rf_we"}, 32'(rf_we),         32'(we));
        chk({tag, ".addr"},  32'(imem_addr),     32'(addr));
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_data = '0; rs_data = '0;
        reset2 = 1'b0; run2 = 1'b0; ack2 = 1'b0; data2 = '0; rs2 = '0;

        // 1. reset held for three cycles
        repeat (3) step();
        chk("rst.state",  32'(current_state), 32'(S_IDLE));
        chk("rst.pc",     32'(pc), 0);
        chk("rst.req",    32'(imem_req), 0);
        chk("rst.rf_we",  32'(rf_we), 0);
        chk("rst.halted", 32'(halted), 0);
        chk("rst.fields", 32'({OPCODE, RD, RA, RB}), 0);

        // 2. ALU op 16'h1234 with zero-wait ack
        reset = 1'b1; run = 1'b1; imem_ack = 1'b1; imem_data = 16'h1234;
        stp("alu.if", S_IF, 1'b1, 1'b0, 8'h00);
        stp("alu.id", S_ID, 1'b0, 1'b0, 8'h01);
        chk("alu.fields", 32'({OPCODE, RD, RA, RB}), 32'h1234);
        chk("alu.pc", 32'(pc), 1);
        stp("alu.rr",  S_RR,  1'b0, 1'b0, 8'h01);
        stp("alu.ex",  S_EX,  1'b0, 1'b0, 8'h01);
        stp("alu.rwb", S_RWB, 1'b0, 1'b1, 8'h01);
        stp("alu.nif", S_IF,  1'b1, 1'b0, 8'h01);

        // 3. store: no RWB
        imem_data = 16'hB123;
        stp("st.id", S_ID, 1'b0, 1'b0, 8'h02);
        chk("st.op", 32'(OPCODE), 32'hB);
        stp("st.rr",  S_RR, 1'b0, 1'b0, 8'h02);
        stp("st.ex",  S_EX, 1'b0, 1'b0, 8'h02);
        stp("st.nif", S_IF, 1'b1, 1'b0, 8'h02);

        // filler store at pc=2 so the BRZ lands at pc=3
        imem_data = 16'hB000;
        repeat (3) step();
        stp("fill.nif", S_IF, 1'b1, 1'b0, 8'h03);

        // 4a. BRZ taken
        imem_data = 16'hC5A6; rs_data = 8'h00;
        stp("brz.id", S_ID, 1'b0, 1'b0, 8'h04);
        chk("brz.op", 32'(OPCODE), 32'hC);
        repeat (2) step();
        stp("brz.taken", S_IF, 1'b1, 1'b0, 8'h56);

        // branch back to 3 (taken, target {0,3})
        imem_data = 16'hC003;
        repeat (3) step();
        stp("brz.back", S_IF, 1'b1, 1'b0, 8'h03);

        // 4b. BRZ not taken
        imem_data = 16'hC5A6; rs_data = 8'h01;
        repeat (3) step();
        stp("brz.nt", S_IF, 1'b1, 1'b0, 8'h04);

        // 5. five wait-state cycles
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) stp("wait", S_IF, 1'b1, 1'b0, 8'h04);
        chk("wait.pc", 32'(pc), 32'h04);
`ifdef MIPS_CTRL_PERF_EN
        chk("perf.stall", 32'(stall_cnt), 5);
        chk("perf.retired", 32'(retired_cnt), 6);
`endif

        // reset mid-wait with a pending ack
        reset = 1'b0; imem_ack = 1'b1;
        stp("mrst", S_IDLE, 1'b0, 1'b0, 8'h00);
        chk("mrst.fields", 32'({OPCODE, RD, RA, RB}), 0);
`ifdef MIPS_CTRL_PERF_EN
        chk("perf.clr", 32'({retired_cnt, stall_cnt}), 0);
`endif

        // 6. HALT with run held high
        reset = 1'b1; imem_data = 16'hF000; rs_data = 8'h00;
        stp("h.if", S_IF, 1'b1, 1'b0, 8'h00);
        stp("h.id", S_ID, 1'b0, 1'b0, 8'h01);
        repeat (2) step();
        stp("h.halt", S_HALT, 1'b0, 1'b0, 8'h01);
        chk("h.halted", 32'(halted), 1);
        repeat (2) stp("h.hold", S_HALT, 1'b0, 1'b0, 8'h01);
        chk("h.held", 32'(halted), 1);
        run = 1'b0;
        stp("h.low", S_HALT, 1'b0, 1'b0, 8'h01);
        run = 1'b1; imem_data = 16'h1234;
        stp("h.resume", S_IF, 1'b1, 1'b0, 8'h01);
        chk("h.cleared", 32'(halted), 0);
`ifdef MIPS_CTRL_PERF_EN
        chk("perf.halt", 32'(retired_cnt), 1);
`endif

        // PC_W=4: branch to 15 (8-bit target 0x0F truncated), then wrap
        reset2 = 1'b1; run2 = 1'b1; ack2 = 1'b1; data2 = 16'hC00F; rs2 = 8'h00;
        step();
        chk("w4.if", 32'({state2, addr2}), 32'({S_IF, 4'h0}));
        repeat (3) step();
        step();
        chk("w4.br", 32'({state2, addr2}), 32'({S_IF, 4'hF}));
        data2 = 16'hB000;
        step();
        chk("w4.wrap", 32'({state2, pc2}), 32'({S_ID, 4'h0}));
        repeat (2) step();
        step();
        chk("w4.nif", 32'({state2, addr2, we2}), 32'({S_IF, 4'h0, 1'b0}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
